usb_cmd_regfile_decoder: RTL and testbench

//  Parametrised command decoder and register file for USB control words, sitting between the USB

---
 rtl/usb_cmd_regfile_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_usb_cmd_regfile_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_regfile_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : usb_cmd_regfile_decoder
//  Description : Decodes USB control words into register writes (short and
//                header+data long form), register read-back, one-shot pulse
//                commands and a saturating error counter with sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_cmd_regfile_decoder #(
    parameter int CMD_W     = 16,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = 4,
    parameter int NUM_PULSE = 8,
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_from_usb_Ctr_rd_en,
    input  logic [CMD_W-1:0]          in_from_usb_ControlWord,
    output logic [NUM_REGS*CMD_W-1:0] out_reg_flat,
    output logic [NUM_REGS-1:0]       out_reg_wr_strobe,
    output logic [NUM_PULSE-1:0]      out_pulse,
    output logic [CMD_W-1:0]          out_rd_data,
    output logic                      out_rd_valid,
    output logic                      out_busy,
    output logic [7:0]                out_err_cnt,
    output logic                      out_err_flag
);

    localparam int c_TMO_W  = $clog2(TIMEOUT);
    localparam int c_PCNT_W = $clog2(PULSE_LEN + 1);

    localparam logic [3:0] c_OP_SHORT_WR = 4'h1;
    localparam logic [3:0] c_OP_LONG_HDR = 4'h2;
    localparam logic [3:0] c_OP_PULSE    = 4'h3;
    localparam logic [3:0] c_OP_READ     = 4'h4;
    localparam logic [3:0] c_OP_CLEAR    = 4'hF;

    localparam logic [ADDR_W:0]  c_NUM_REGS_X  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [8:0]       c_NUM_PULSE_X = 9'(NUM_PULSE);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_lat_addr;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic [CMD_W-1:0]      r_regs [NUM_REGS];
    logic [c_PCNT_W-1:0]   r_pulse_cnt [NUM_PULSE];

    // Field extraction from the incoming word
    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_short_addr;
    logic [7:0]        w_idx;
    logic              w_addr_ok;
    logic              w_short_ok;
    logic              w_idx_ok;

    assign w_op         = in_from_usb_ControlWord[CMD_W-1 -: 4];
    assign w_addr       = in_from_usb_ControlWord[ADDR_W-1:0];
    assign w_short_addr = ADDR_W'(in_from_usb_ControlWord[11:8]);
    assign w_idx        = in_from_usb_ControlWord[7:0];
    assign w_addr_ok    = {1'b0, w_addr} < c_NUM_REGS_X;
    assign w_short_ok   = {1'b0, w_short_addr} < c_NUM_REGS_X;
    assign w_idx_ok     = {1'b0, w_idx} < c_NUM_PULSE_X;

    // Decode actions for this cycle
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [CMD_W-1:0]  w_wr_data;
    logic              w_hdr_latch;
    logic              w_pulse_fire;
    logic              w_rd_fire;
    logic              w_err;
    logic              w_clr;
    logic [CMD_W-1:0]  w_rd_mux;

    // Next-state and command decode
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = '0;
        w_wr_data    = '0;
        w_hdr_latch  = 1'b0;
        w_pulse_fire = 1'b0;
        w_rd_fire    = 1'b0;
        w_err        = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_from_usb_Ctr_rd_en) begin
                    case (w_op)
                        c_OP_SHORT_WR: begin
                            if (w_short_ok) begin
                                w_wr_en   = 1'b1;
                                w_wr_addr = w_short_addr;
                                w_wr_data = CMD_W'(in_from_usb_ControlWord[7:0]);
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        c_OP_LONG_HDR: begin
                            if (w_addr_ok) begin
                                w_hdr_latch = 1'b1;
                                w_state_nxt = ST_WAIT_DATA;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        c_OP_PULSE: begin
                            if (w_idx_ok) w_pulse_fire = 1'b1;
                            else          w_err        = 1'b1;
                        end
                        c_OP_READ: begin
                            if (w_addr_ok) w_rd_fire = 1'b1;
                            else           w_err     = 1'b1;
                        end
                        c_OP_CLEAR: begin
                            if (in_from_usb_ControlWord[11:0] == 12'h000) w_clr = 1'b1;
                            else                                           w_err = 1'b1;
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            ST_WAIT_DATA: begin
                // Any word arriving here is data, whatever it looks like
                if (in_from_usb_Ctr_rd_en) begin
                    w_wr_en     = 1'b1;
                    w_wr_addr   = r_lat_addr;
                    w_wr_data   = in_from_usb_ControlWord;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, latched long-write address and idle timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_lat_addr <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hdr_latch) begin
                r_lat_addr <= w_addr;
                r_tmo_cnt  <= '0;
            end else if (r_state == ST_WAIT_DATA && !in_from_usb_Ctr_rd_en) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
        end
    end

    // Register file with one-cycle write strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            out_reg_wr_strobe <= '0;
        end else begin
            out_reg_wr_strobe <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_en && w_wr_addr == ADDR_W'(i)) begin
                    r_regs[i]            <= w_wr_data;
                    out_reg_wr_strobe[i] <= 1'b1;
                end
            end
        end
    end

    // Read-back multiplexer
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr == ADDR_W'(i)) w_rd_mux = r_regs[i];
        end
    end

    // Read-back data register and single-cycle valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_rd_data  <= '0;
            out_rd_valid <= 1'b0;
        end else begin
            out_rd_valid <= w_rd_fire;
            if (w_rd_fire) out_rd_data <= w_rd_mux;
        end
    end

    // Per-channel pulse counters; a new command reloads the full length
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PULSE; i++) r_pulse_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PULSE; i++) begin
                if (w_pulse_fire && w_idx == 8'(i)) begin
                    r_pulse_cnt[i] <= c_PCNT_W'(PULSE_LEN);
                end else if (r_pulse_cnt[i] != '0) begin
                    r_pulse_cnt[i] <= r_pulse_cnt[i] - c_PCNT_W'(1);
                end
            end
        end
    end

    // Saturating error counter and sticky flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_err_cnt  <= 8'd0;
            out_err_flag <= 1'b0;
        end else if (w_clr) begin
            out_err_cnt  <= 8'd0;
            out_err_flag <= 1'b0;
        end else if (w_err) begin
            if (out_err_cnt != 8'hFF) out_err_cnt <= out_err_cnt + 8'd1;
            out_err_flag <= 1'b1;
        end
    end

    assign out_busy = (r_state == ST_WAIT_DATA);

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign out_reg_flat[g*CMD_W +: CMD_W] = r_regs[g];
        end
        for (genvar g = 0; g < NUM_PULSE; g++) begin : g_pulse
            assign out_pulse[g] = (r_pulse_cnt[g] != '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_usb_cmd_regfile_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_cmd_regfile_decoder
//  Description : Self-checking bench for usb_cmd_regfile_decoder: vector
//                table, directed corner sequences and random traffic against
//                a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_cmd_regfile_decoder;

    localparam int NR = 16;
    localparam int NP = 8;
    localparam int PL = 4;
    localparam int TO = 1024;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           rd_en = 1'b0;
    logic [15:0]    word = '0;
    logic [NR*16-1:0] reg_flat;
    logic [NR-1:0]  strobe;
    logic [NP-1:0]  pulse;
    logic [15:0]    rd_data;
    logic           rd_valid;
    logic           busy;
    logic [7:0]     err_cnt;
    logic           err_flag;

    int n_cmp = 0;
    int n_bad = 0;

    usb_cmd_regfile_decoder #(
        .CMD_W(16), .NUM_REGS(NR), .ADDR_W(4),
        .NUM_PULSE(NP), .PULSE_LEN(PL), .TIMEOUT(TO)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .in_from_usb_Ctr_rd_en   (rd_en),
        .in_from_usb_ControlWord (word),
        .out_reg_flat            (reg_flat),
        .out_reg_wr_strobe       (strobe),
        .out_pulse               (pulse),
        .out_rd_data             (rd_data),
        .out_rd_valid            (rd_valid),
        .out_busy                (busy),
        .out_err_cnt             (err_cnt),
        .out_err_flag            (err_flag)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_reg [NR];
    int          m_pulse [NP];
    bit          m_busy;
    int          m_la;
    int          m_idle;
    int          m_err;
    bit          m_flag;
    logic [NR-1:0] m_strobe;
    bit          m_rdv;
    logic [15:0] m_rdd;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        for (int i = 0; i < NP; i++) m_pulse[i] = 0;
        m_busy = 0; m_la = 0; m_idle = 0; m_err = 0; m_flag = 0;
        m_strobe = '0; m_rdv = 0; m_rdd = '0;
    endtask

    task automatic model_step(input bit en, input logic [15:0] w);
        bit bad;
        int op;
        int a;
        bad = 0;
        op = int'(w[15:12]);
        m_strobe = '0;
        m_rdv = 0;
        for (int i = 0; i < NP; i++) if (m_pulse[i] > 0) m_pulse[i]--;
        if (m_busy) begin
            if (en) begin
                m_reg[m_la] = w;
                m_strobe[m_la] = 1'b1;
                m_busy = 0;
            end else begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_busy = 0;
                    bad = 1;
                end
            end
        end else if (en) begin
            case (op)
                1: begin
                    a = int'(w[11:8]);
                    if (a < NR) begin
                        m_reg[a] = {8'h00, w[7:0]};
                        m_strobe[a] = 1'b1;
                    end else bad = 1;
                end
                2: begin
                    a = int'(w[3:0]);
                    if (a < NR) begin
                        m_la = a; m_busy = 1; m_idle = 0;
                    end else bad = 1;
                end
                3: begin
                    a = int'(w[7:0]);
                    if (a < NP) m_pulse[a] = PL;
                    else bad = 1;
                end
                4: begin
                    a = int'(w[3:0]);
                    if (a < NR) begin
                        m_rdd = m_reg[a]; m_rdv = 1;
                    end else bad = 1;
                end
                15: begin
                    if (w[11:0] == 12'h000) begin
                        m_err = 0; m_flag = 0;
                    end else bad = 1;
                end
                default: bad = 1;
            endcase
        end
        if (bad) begin
            if (m_err < 255) m_err++;
            m_flag = 1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NR*16-1:0] ef;
        logic [NP-1:0]    ep;
        for (int i = 0; i < NR; i++) ef[i*16 +: 16] = m_reg[i];
        for (int i = 0; i < NP; i++) ep[i] = (m_pulse[i] > 0);
        chk("model_reg_flat", 256'(reg_flat), 256'(ef));
        chk("model_strobe",   256'(strobe),   256'(m_strobe));
        chk("model_pulse",    256'(pulse),    256'(ep));
        chk("model_rd_valid", 256'(rd_valid), 256'(m_rdv));
        chk("model_rd_data",  256'(rd_data),  256'(m_rdd));
        chk("model_busy",     256'(busy),     256'(m_busy));
        chk("model_err_cnt",  256'(err_cnt),  256'(m_err));
        chk("model_err_flag", 256'(err_flag), 256'(m_flag));
    endtask

    // One clock: drive inputs, advance model at the edge, check just after
    task automatic cycle(input bit en, input logic [15:0] w);
        rd_en = en;
        word  = w;
        @(posedge clk);
        model_step(en, w);
        #1;
        rd_en = 1'b0;
        compare_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] word;
        int          reg_idx;
        logic [15:0] reg_val;
        logic [15:0] strb;
        logic        rdv;
        logic [15:0] rdd;
        int          err;
        logic        bsy;
    } vec_t;

    vec_t tbl [13];

    initial begin : main
        int n;
        logic [15:0] w;
        bit en;
        int sel;

        tbl[0]  = '{16'h1A5C, 10, 16'h005C, 16'h0400, 1'b0, 16'h0000, 0, 1'b0};
        tbl[1]  = '{16'h1BFF, 11, 16'h00FF, 16'h0800, 1'b0, 16'h0000, 0, 1'b0};
        tbl[2]  = '{16'h400A, 10, 16'h005C, 16'h0000, 1'b1, 16'h005C, 0, 1'b0};
        tbl[3]  = '{16'h2003,  3, 16'h0000, 16'h0000, 1'b0, 16'h005C, 0, 1'b1};
        tbl[4]  = '{16'hBEEF,  3, 16'hBEEF, 16'h0008, 1'b0, 16'h005C, 0, 1'b0};
        tbl[5]  = '{16'h4013,  3, 16'hBEEF, 16'h0000, 1'b1, 16'hBEEF, 0, 1'b0};
        tbl[6]  = '{16'h7000,  3, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 1, 1'b0};
        tbl[7]  = '{16'h3009,  3, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 2, 1'b0};
        tbl[8]  = '{16'hF001,  3, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 3, 1'b0};
        tbl[9]  = '{16'hF000,  3, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 0, 1'b0};
        tbl[10] = '{16'h2005,  5, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 0, 1'b1};
        tbl[11] = '{16'h2005,  5, 16'h2005, 16'h0020, 1'b0, 16'hBEEF, 0, 1'b0};
        tbl[12] = '{16'h1512,  5, 16'h0012, 16'h0020, 1'b0, 16'hBEEF, 0, 1'b0};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_flat_zero", 256'(reg_flat), 256'd0);
        reset_n = 1'b1;

        // Table-driven vectors (back-to-back words)
        for (int k = 0; k < 13; k++) begin
            cycle(1'b1, tbl[k].word);
            chk($sformatf("tbl%0d_reg", k), 256'(reg_flat[tbl[k].reg_idx*16 +: 16]), 256'(tbl[k].reg_val));
            chk($sformatf("tbl%0d_strobe", k), 256'(strobe), 256'(tbl[k].strb));
            chk($sformatf("tbl%0d_rd_valid", k), 256'(rd_valid), 256'(tbl[k].rdv));
            chk($sformatf("tbl%0d_rd_data", k), 256'(rd_data), 256'(tbl[k].rdd));
            chk($sformatf("tbl%0d_err_cnt", k), 256'(err_cnt), 256'(tbl[k].err));
            chk($sformatf("tbl%0d_busy", k), 256'(busy), 256'(tbl[k].bsy));
        end

        // Long write with a gap before the data word
        cycle(1'b1, 16'h2007);
        repeat (4) cycle(1'b0, 16'h0000);
        chk("gap_busy", 256'(busy), 256'd1);
        cycle(1'b1, 16'h1234);
        chk("gap_reg7", 256'(reg_flat[7*16 +: 16]), 256'h1234);
        chk("gap_busy_done", 256'(busy), 256'd0);

        // Long-write timeout: no write, one error, then clear
        cycle(1'b1, 16'h2003);
        repeat (TO - 1) cycle(1'b0, 16'h0000);
        chk("tmo_busy_before", 256'(busy), 256'd1);
        cycle(1'b0, 16'h0000);
        chk("tmo_busy_after", 256'(busy), 256'd0);
        chk("tmo_err_cnt", 256'(err_cnt), 256'd1);
        chk("tmo_err_flag", 256'(err_flag), 256'd1);
        chk("tmo_reg3_kept", 256'(reg_flat[3*16 +: 16]), 256'hBEEF);
        cycle(1'b1, 16'hF000);
        chk("clr_err_cnt", 256'(err_cnt), 256'd0);
        chk("clr_err_flag", 256'(err_flag), 256'd0);

        // Single pulse length
        n = 0;
        cycle(1'b1, 16'h3002);
        if (pulse[2]) n++;
        repeat (10) begin
            cycle(1'b0, 16'h0000);
            if (pulse[2]) n++;
        end
        chk("pulse_len", 256'(n), 256'd4);

        // Retrigger two cycles after the first accept
        n = 0;
        cycle(1'b1, 16'h3002);
        if (pulse[2]) n++;
        cycle(1'b0, 16'h0000);
        if (pulse[2]) n++;
        cycle(1'b1, 16'h3002);
        if (pulse[2]) n++;
        repeat (10) begin
            cycle(1'b0, 16'h0000);
            if (pulse[2]) n++;
        end
        chk("pulse_retrig_len", 256'(n), 256'd6);

        // Concurrent channels
        cycle(1'b1, 16'h3000);
        cycle(1'b1, 16'h3007);
        chk("pulse_concurrent", 256'(pulse), 256'h81);
        repeat (6) cycle(1'b0, 16'h0000);

        // Error saturation with no pulse side effects
        cycle(1'b1, 16'h3009);
        cycle(1'b1, 16'h7000);
        repeat (300) cycle(1'b1, 16'h7000);
        chk("sat_err_cnt", 256'(err_cnt), 256'd255);
        chk("sat_err_flag", 256'(err_flag), 256'd1);
        chk("sat_no_pulse", 256'(pulse), 256'd0);
        cycle(1'b1, 16'hF000);

        // Asynchronous reset in the middle of a pulse and a long write
        cycle(1'b1, 16'h3001);
        cycle(1'b1, 16'h2004);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_pulse", 256'(pulse), 256'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 16'h5555);
        chk("midrst_no_partial", 256'(reg_flat[4*16 +: 16]), 256'h0000);

        // Random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            w   = 16'($urandom);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: w[15:12] = 4'h1;
                1: w[15:12] = 4'h2;
                2: begin w[15:12] = 4'h3; w[7:0] = 8'($urandom_range(0, 11)); end
                3: w[15:12] = 4'h4;
                4: begin w[15:12] = 4'hF; if ($urandom_range(0, 1) == 0) w[11:0] = 12'h000; end
                default: ;
            endcase
            cycle(en, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
